// File: rtl/dc_seg_display.sv
// rtl/dc_seg_display.sv - live/history/count back-end for an 8-digit multiplexed 7-segment display
module dc_seg_display #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int SCAN_DIV     = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dc_dec,
  input  logic       btn_cap,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);
  localparam logic [6:0]    BLANK     = 7'h7F;

  logic          s1, s2, stable, stable_q, cap;
  logic [DW-1:0] dcnt;
  logic [3:0]    hist [4];
  logic [3:0]    valid;
  logic [7:0]    cnt;
  logic [PW-1:0] psc;
  logic [2:0]    idx;
  logic [3:0]    digit_val;
  logic          digit_blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Sync, debounce and rising-edge capture pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cap      <= 1'b0;
      dcnt     <= '0;
    end else begin
      s1       <= btn_cap;
      s2       <= s1;
      stable_q <= stable;
      cap      <= stable & ~stable_q;
      if (s2 == stable) begin
        dcnt <= '0;
      end else if (dcnt == DB_LAST) begin
        stable <= s2;
        dcnt   <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist[i] <= 4'h0;
      valid <= 4'h0;
      cnt   <= 8'h00;
    end else if (cap) begin
      hist[0] <= dc_dec;
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
      valid <= {valid[2:0], 1'b1};
      cnt   <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc <= '0;
      idx <= 3'd0;
    end else if (psc == SCAN_LAST) begin
      psc <= '0;
      idx <= idx + 3'd1;
    end else begin
      psc <= psc + 1'b1;
    end
  end

  always_comb begin
    digit_val   = 4'h0;
    digit_blank = 1'b0;
    case (idx)
      3'd0: digit_val = dc_dec;
      3'd1: begin digit_val = hist[0]; digit_blank = ~valid[0]; end
      3'd2: begin digit_val = hist[1]; digit_blank = ~valid[1]; end
      3'd3: begin digit_val = hist[2]; digit_blank = ~valid[2]; end
      3'd4: begin digit_val = hist[3]; digit_blank = ~valid[3]; end
      3'd5: digit_blank = 1'b1;
      3'd6: digit_val = cnt[3:0];
      default: digit_val = cnt[7:4];
    endcase
  end

  // One register stage for an/seg/dp so they always move together
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an  <= 8'hFF;
      seg <= BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'b1 << idx);
      seg <= digit_blank ? BLANK : hex7(digit_val);
      dp  <= (idx != 3'd0);
    end
  end

endmodule
